// File: rtl/masked_subbytes_sched.sv
// Purpose: byte-serial SubBytes sequencer feeding one pipelined masked sbox and reassembling its shared result.
// Latency: byte k issued in cycle 2+k after start, captured LATENCY cycles later, DonexSO at cycle 18+LATENCY without bubbles.
// Backpressure: none toward the sbox; a missing RndValidxSI inserts an all-zero bubble and delays later events by one cycle.
module masked_subbytes_sched #(
    parameter int SHARES  = 2,
    parameter int LATENCY = 4
) (
    input  logic                    ClkxCI,
    input  logic                    RstxBI,
    input  logic                    StartxSI,
    input  logic [128*SHARES-1:0]   StatexDI,
    input  logic                    RndValidxSI,
    input  logic [8*SHARES-1:0]     SboxOutxDI,
    output logic [8*SHARES-1:0]     SboxInxDO,
    output logic                    IssuexSO,
    output logic                    BusyxSO,
    output logic                    DonexSO,
    output logic [128*SHARES-1:0]   StatexDO
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]              fsm;
    logic [128*SHARES-1:0]   state_lat;
    logic [3:0]              idx;
    logic [3:0]              iss_idx;
    logic [4:0]              cap_cnt;
    logic [LATENCY-1:0]      tag_vld;
    logic [3:0]              tag_idx [LATENCY];
    logic [8*SHARES-1:0]     byte_sel;
    logic                    start_acc;
    logic                    load_byte;
    logic                    capture;
    logic [3:0]              cap_idx;

    assign start_acc = (fsm == ST_IDLE) && StartxSI;
    assign load_byte = (fsm == ST_ISSUE) && RndValidxSI;
    assign capture   = tag_vld[LATENCY-1];
    assign cap_idx   = tag_idx[LATENCY-1];
    assign BusyxSO   = (fsm != ST_IDLE);
    assign DonexSO   = (fsm == ST_DONE);

    // Per-share byte mux; the select is the public byte index, so no share ever meets another.
    always_comb begin
        byte_sel = '0;
        for (int s = 0; s < SHARES; s++) begin
            byte_sel[8*s +: 8] = state_lat[128*s + 8*int'(idx) +: 8];
        end
    end

    // Sequencer: issue all 16 bytes, wait for the last capture, pulse done for one cycle.
    always_ff @(posedge ClkxCI or posedge RstxBI) begin
        if (RstxBI) begin
            fsm <= ST_IDLE;
        end else begin
            case (fsm)
                ST_IDLE:  if (StartxSI) fsm <= ST_ISSUE;
                ST_ISSUE: if (RndValidxSI && (idx == 4'd15)) fsm <= ST_DRAIN;
                ST_DRAIN: if (capture && (cap_cnt == 5'd15)) fsm <= ST_DONE;
                default:  fsm <= ST_IDLE;
            endcase
        end
    end

    // Input latch and byte index; a start is only honoured from IDLE so a held start cannot re-latch.
    always_ff @(posedge ClkxCI or posedge RstxBI) begin
        if (RstxBI) begin
            state_lat <= '0;
            idx       <= '0;
        end else if (start_acc) begin
            state_lat <= StatexDI;
            idx       <= '0;
        end else if (load_byte && (idx != 4'd15)) begin
            idx       <= idx + 4'd1;
        end
    end

    // Registered sbox input: the flop is the glitch barrier, bubbles drive all-zero shares.
    always_ff @(posedge ClkxCI or posedge RstxBI) begin
        if (RstxBI) begin
            SboxInxDO <= '0;
            IssuexSO  <= 1'b0;
            iss_idx   <= '0;
        end else begin
            SboxInxDO <= load_byte ? byte_sel : '0;
            IssuexSO  <= load_byte;
            iss_idx   <= load_byte ? idx : 4'd0;
        end
    end

    // Tag pipe mirrors the sbox depth so the tail lines up with the returning byte.
    always_ff @(posedge ClkxCI or posedge RstxBI) begin
        if (RstxBI) begin
            tag_vld <= '0;
            for (int j = 0; j < LATENCY; j++) tag_idx[j] <= '0;
        end else begin
            tag_vld[0] <= IssuexSO;
            tag_idx[0] <= iss_idx;
            for (int j = 1; j < LATENCY; j++) begin
                tag_vld[j] <= tag_vld[j-1];
                tag_idx[j] <= tag_idx[j-1];
            end
        end
    end

    // Capture counter restarts with each accepted start; the result register is not cleared.
    always_ff @(posedge ClkxCI or posedge RstxBI) begin
        if (RstxBI) begin
            cap_cnt <= '0;
        end else if (start_acc) begin
            cap_cnt <= '0;
        end else if (capture) begin
            cap_cnt <= cap_cnt + 5'd1;
        end
    end

    // Write each returning shared byte into its slot, share by share.
    always_ff @(posedge ClkxCI or posedge RstxBI) begin
        if (RstxBI) begin
            StatexDO <= '0;
        end else if (capture) begin
            for (int s = 0; s < SHARES; s++) begin
                StatexDO[128*s + 8*int'(cap_idx) +: 8] <= SboxOutxDI[8*s +: 8];
            end
        end
    end

endmodule

// File: tb/tb_masked_subbytes_sched.sv
// Purpose: directed/random bench for masked_subbytes_sched with a recombining AES sbox model.
// Latency: the sbox model delays LAT cycles and re-splits its output with fresh random masks.
// Backpressure: RndValidxSI patterns (constant, toggling, long gap, random) exercise bubble insertion.
module tb_masked_subbytes_sched;

    localparam int SHARES = 2;
    localparam int LAT    = 4;
    localparam int W      = 128*SHARES;

    logic                ClkxCI = 1'b0;
    logic                RstxBI = 1'b1;
    logic                StartxSI = 1'b0;
    logic [W-1:0]        StatexDI = '0;
    logic                RndValidxSI = 1'b0;
    logic [8*SHARES-1:0] SboxOutxDI;
    logic [8*SHARES-1:0] SboxInxDO;
    logic                IssuexSO;
    logic                BusyxSO;
    logic                DonexSO;
    logic [W-1:0]        StatexDO;

    int total = 0;
    int bad   = 0;

    masked_subbytes_sched #(.SHARES(SHARES), .LATENCY(LAT)) dut (
        .ClkxCI(ClkxCI), .RstxBI(RstxBI), .StartxSI(StartxSI), .StatexDI(StatexDI),
        .RndValidxSI(RndValidxSI), .SboxOutxDI(SboxOutxDI), .SboxInxDO(SboxInxDO),
        .IssuexSO(IssuexSO), .BusyxSO(BusyxSO), .DonexSO(DonexSO), .StatexDO(StatexDO)
    );

    always #5 ClkxCI = ~ClkxCI;

    // ---------------- AES reference arithmetic ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return 8'((b << n) | (b >> (8 - n)));
    endfunction

    // S(x) = affine(x^254) in GF(2^8)
    function automatic logic [7:0] aes_s(input logic [7:0] x);
        logic [7:0] t;
        t = 8'h01;
        for (int i = 0; i < 254; i++) t = gmul(t, x);
        return t ^ rotl8(t, 1) ^ rotl8(t, 2) ^ rotl8(t, 3) ^ rotl8(t, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] x);
        logic [127:0] r;
        r = '0;
        for (int k = 0; k < 16; k++) r[8*k +: 8] = aes_s(x[8*k +: 8]);
        return r;
    endfunction

    function automatic logic [127:0] recomb(input logic [W-1:0] v);
        logic [127:0] r;
        r = '0;
        for (int s = 0; s < SHARES; s++) r = r ^ v[128*s +: 128];
        return r;
    endfunction

    function automatic logic [W-1:0] rand_state();
        logic [W-1:0] v;
        v = '0;
        for (int i = 0; i < W/32; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    // ---------------- masked sbox model ----------------
    logic [127:0]        rnd_q;
    logic [8*SHARES-1:0] sb_next;
    logic [8*SHARES-1:0] sb_pipe [LAT];
    logic [7:0]          sb_acc;
    logic [7:0]          sb_val;

    always @(posedge ClkxCI) rnd_q <= {$urandom, $urandom, $urandom, $urandom};

    always_comb begin
        sb_next = '0;
        sb_acc  = 8'h00;
        for (int s = 0; s < SHARES; s++) sb_acc = sb_acc ^ SboxInxDO[8*s +: 8];
        sb_val = aes_s(sb_acc);
        for (int s = 1; s < SHARES; s++) begin
            sb_next[8*s +: 8] = rnd_q[8*s +: 8];
            sb_val = sb_val ^ rnd_q[8*s +: 8];
        end
        sb_next[7:0] = sb_val;
    end

    always @(posedge ClkxCI) begin
        sb_pipe[0] <= sb_next;
        for (int j = 1; j < LAT; j++) sb_pipe[j] <= sb_pipe[j-1];
    end

    assign SboxOutxDI = sb_pipe[LAT-1];

    // ---------------- bench helpers ----------------
    task automatic step();
        @(posedge ClkxCI);
        #1;
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // mode 0: always valid; 1: toggles 1,0,1,0 from cycle 1; 2: low for cycles 1..30; 3: random
    function automatic bit rnd_at(input int mode, input int n);
        case (mode)
            0:       return 1'b1;
            1:       return n[0];
            2:       return (n > 30);
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    int           g_done, g_niss, g_first, g_last, g_ndone, g_busylow;
    int           g_explow, g_expfirst, g_explast;
    logic [W-1:0] g_in, g_res, g_snap, g_alt;

    // Start in the current cycle (cycle 0) and run until the first done or a cycle budget.
    task automatic run_op(input int mode, input bit hold);
        int hi;
        bit r;
        hi = 0; g_explow = 0; g_expfirst = -1; g_explast = -1;
        g_done = -1; g_niss = 0; g_first = -1; g_last = -1; g_ndone = 0; g_busylow = 0;
        g_in = StatexDI; g_snap = StatexDO;
        StartxSI = 1'b1; RndValidxSI = 1'b1;
        step();
        if (!hold) StartxSI = 1'b0;
        for (int n = 1; n < 300 && g_done < 0; n++) begin
            r = rnd_at(mode, n);
            RndValidxSI = r;
            if (hi < 16) begin
                if (r) begin
                    hi++;
                    if (g_expfirst < 0) g_expfirst = n + 1;
                    if (hi == 16) g_explast = n + 1;
                end else begin
                    g_explow++;
                end
            end
            if (hold && n == 5) StatexDI = g_alt;
            if (mode == 2 && n == 30) chk("gap_no_capture", StatexDO, g_snap);
            if (IssuexSO) begin
                g_niss++;
                if (g_first < 0) g_first = n;
                g_last = n;
            end
            if (!BusyxSO) g_busylow++;
            if (DonexSO) begin
                g_ndone++;
                g_done = n;
                g_res  = StatexDO;
            end
            step();
        end
        RndValidxSI = 1'b0;
    endtask

    task automatic check_op(input string p);
        chk({p, "_done_cycle"}, W'(g_done), W'(18 + LAT + g_explow));
        chk({p, "_issues"}, W'(g_niss), W'(16));
        chk({p, "_first_issue"}, W'(g_first), W'(g_expfirst));
        chk({p, "_last_issue"}, W'(g_last), W'(g_explast));
        chk({p, "_busy"}, W'(g_busylow), W'(0));
        chk({p, "_ndone"}, W'(g_ndone), W'(1));
        chk({p, "_result"}, W'(recomb(g_res)), W'(sub_bytes(recomb(g_in))));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [127:0] r1;
        logic [W-1:0] s;
        int seen;

        // reset state
        #1;
        chk("rst_busy", W'(BusyxSO), W'(0));
        step(); step();
        chk("rst_issue", W'(IssuexSO), W'(0));
        chk("rst_done", W'(DonexSO), W'(0));
        chk("rst_sboxin", W'(SboxInxDO), W'(0));
        chk("rst_stateout", StatexDO, '0);
        RstxBI = 1'b0;
        step();

        // 1: counting bytes, no bubbles
        s = '0;
        for (int k = 0; k < 16; k++) s[8*k +: 8] = 8'(k);
        StatexDI = s;
        run_op(0, 1'b0);
        check_op("s1");
        r1 = recomb(g_res);
        chk("s1_byte0", W'(r1[7:0]), W'(8'h63));
        chk("s1_byte1", W'(r1[15:8]), W'(8'h7c));
        chk("s1_byte15", W'(r1[127:120]), W'(8'h76));
        chk("s1_done_22", W'(g_done), W'(18 + LAT));
        step();

        // 2: random shares, toggling randomness
        StatexDI = rand_state();
        run_op(1, 1'b0);
        check_op("s2");
        step();

        // 2b: random shares, random randomness
        StatexDI = rand_state();
        run_op(3, 1'b0);
        check_op("s2r");
        step();

        // 3: start held high; mid-op input change must not be re-latched
        StatexDI = rand_state();
        g_alt = rand_state();
        run_op(0, 1'b1);
        check_op("s3");
        chk("s3_idle_after_done", W'(BusyxSO), W'(0));
        chk("s3_single_done", W'(DonexSO), W'(0));
        step();
        chk("s3_restart", W'(BusyxSO), W'(1));
        StartxSI = 1'b0;
        RndValidxSI = 1'b1;
        seen = 0;
        for (int n = 0; n < 60 && seen == 0; n++) begin
            if (DonexSO) begin
                seen = 1;
                chk("s3_second_result", W'(recomb(StatexDO)), W'(sub_bytes(recomb(g_alt))));
            end
            step();
        end
        chk("s3_second_done_seen", W'(seen), W'(1));
        RndValidxSI = 1'b0;
        step();

        // 4: reset in cycle 10 of an operation
        StatexDI = rand_state();
        StartxSI = 1'b1; RndValidxSI = 1'b1;
        step();
        StartxSI = 1'b0;
        repeat (9) step();
        RstxBI = 1'b1;
        #1;
        chk("s4_busy", W'(BusyxSO), W'(0));
        chk("s4_issue", W'(IssuexSO), W'(0));
        chk("s4_sboxin", W'(SboxInxDO), W'(0));
        chk("s4_stateout", StatexDO, '0);
        step();
        chk("s4_done", W'(DonexSO), W'(0));
        step();
        RstxBI = 1'b0;
        StatexDI = rand_state();
        run_op(0, 1'b0);
        check_op("s4");
        step();

        // 5: thirty cycles without randomness
        StatexDI = rand_state();
        run_op(2, 1'b0);
        check_op("s5");
        chk("s5_first_issue_32", W'(g_first), W'(32));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
